mc_datapath: RTL and testbench
==============================

MC_DATAPATH -- requirements
Module: mc_datapath

Interface
REQ-001 Parameter DATA_W, 16: register/ALU/data-memory word width, SHALL be >=16.
REQ-002 Parameter PC_W, 16: PC and instruction-address width, SHALL be >=12.
REQ-003 Parameter DADDR_W, 16: data-memory address width, SHALL be <=DATA_W.
REQ-004 Parameter RESET_PC, 0: PC value loaded on reset.
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 jump, beq, bne, mem_read_en, mem_write_en, alu_src, reg_dst, mem_to_reg, reg_write_en  in  1 each  decoded controls from control unit, functions of opcode.
REQ-008 alu_op  in  3  ALU operation select.
REQ-009 opcode  out  4  IR[15:12].
REQ-010 imem_req  out  1; imem_addr  out  PC_W; imem_ack  in  1; imem_rdata  in  16: instruction fetch port.
REQ-011 dmem_req  out  1; dmem_we  out  1; dmem_addr  out  DADDR_W; dmem_wdata  out  DATA_W; dmem_ack  in  1; dmem_rdata  in  DATA_W: data port.
REQ-012 pc  out  PC_W  current PC; retire  out  1  one-cycle pulse per completed instruction.

Function
REQ-013 FSM states FETCH, DECODE, EXEC, MEM, WB; one instruction in flight.
REQ-014 FETCH: imem_req=1, imem_addr=pc; on edge with imem_ack=1 latch imem_rdata into IR, go DECODE; else stay.
REQ-015 DECODE (1 cycle): latch A=R[IR[11:9]], B=R[IR[8:6]].
REQ-016 EXEC (1 cycle): ALUOut=ALU(A, alu_src ? sext(IR[5:0]) to DATA_W : B), latch zero flag (ALUOut==0).
REQ-017 ALU ops: 000 add, 001 sub, 010 ~a, 011 a<<b[3:0], 100 a>>b[3:0] logical, 101 and, 110 or, 111 slt signed (1/0); results mod 2^DATA_W.
REQ-018 EXEC exit: jump or beq/bne taken -> update PC, retire, FETCH; mem_read_en or mem_write_en -> MEM; reg_write_en -> WB; else PC+1, retire, FETCH.
REQ-019 Next PC: jump -> {pc_plus_1[PC_W-1:12], IR[11:0]}; else taken branch -> pc+1+sext(IR[5:0]); else pc+1; all mod 2^PC_W; jump beats branch.
REQ-020 Branch taken = (beq & zero) | (bne & ~zero).
REQ-021 MEM: dmem_req=1, dmem_addr=ALUOut[DADDR_W-1:0], dmem_wdata=B, dmem_we=mem_write_en; all held stable until ack.
REQ-022 MEM on ack: store -> PC+1, retire, FETCH; load -> latch MDR=dmem_rdata, go WB.
REQ-023 mem_read_en and mem_write_en both 1: treated as store; no register write.
REQ-024 WB (1 cycle): if reg_write_en write R[reg_dst ? IR[5:3] : IR[8:6]] = mem_to_reg ? MDR : ALUOut; PC+1, retire, FETCH.
REQ-025 Ack sampled only while corresponding req high; ack with req low ignored; ack in first req cycle accepted.
REQ-026 Zero-wait latency: branch/jump 3 cycles, ALU/store 4, load 5; each wait cycle adds 1.
REQ-027 PC updates exactly once per instruction, same edge as retire; PC wraps 2^PC_W-1 -> 0.
REQ-028 R0 is an ordinary writable register.

Reset
REQ-029 rst_n low: state=FETCH, pc=RESET_PC, IR/A/B/ALUOut/MDR/zero=0, all 8 registers=0, retire=0, dmem_req=0.
REQ-030 Reset mid-transaction drops dmem_req asynchronously; outstanding ack after release is ignored unless in FETCH with imem_req.
REQ-031 First imem_req asserted on first rising edge after rst_n deasserts.

Structure
REQ-032 Package mc_dp_pkg: FSM state enum, ALU op constants, IR field positions (opcode, rs1, rs2, rd, imm6, jaddr12).
REQ-033 Sub-module mc_regfile: 8 x DATA_W, two async read ports, one sync write port, async reset.

Verification
REQ-034 Reset then imem_ack always 1, IR=add r2=r0+r1 with r0=3,r1=4 -> R2=7 after 4 cycles, retire once, pc=1.
REQ-035 Load, DATA_W=32, dmem_ack delayed 3 cycles, rdata=0xDEADBEEF -> dmem_req held 4 cycles, addr stable, target reg=0xDEADBEEF, 8 cycles total.
REQ-036 beq with equal operands, imm6=0x3E (-2) at pc=5 -> pc=4; bne same operands -> pc=6.
REQ-037 jump IR[11:0]=0xABC at pc=0x1FFF -> pc=0x2ABC; PC_W=12 branch at pc=0xFFF not taken -> pc=0x000.
REQ-038 rst_n low during MEM wait -> dmem_req 0 same cycle, pc=RESET_PC, no register write, late dmem_ack ignored.
REQ-039 mem_read_en=mem_write_en=1 -> dmem_we=1, no register write, 4 cycles zero-wait.

Source files
------------

// File: rtl/mc_dp_pkg.sv
// mc_dp_pkg: shared definitions for the multi-cycle datapath.
//   state_e      controller state encoding
//   ALU_*        alu_op encodings
//   *_MSB/*_LSB  instruction-register field positions
package mc_dp_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_NOT = 3'b010;
  localparam logic [2:0] ALU_SLL = 3'b011;
  localparam logic [2:0] ALU_SRL = 3'b100;
  localparam logic [2:0] ALU_AND = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam int OPC_MSB   = 15;
  localparam int OPC_LSB   = 12;
  localparam int RS1_MSB   = 11;
  localparam int RS1_LSB   = 9;
  localparam int RS2_MSB   = 8;
  localparam int RS2_LSB   = 6;
  localparam int RD_MSB    = 5;
  localparam int RD_LSB    = 3;
  localparam int IMM_MSB   = 5;
  localparam int IMM_LSB   = 0;
  localparam int JADDR_MSB = 11;
  localparam int JADDR_LSB = 0;

endpackage

// File: rtl/mc_regfile.sv
// mc_regfile: 8 x DATA_W general-purpose registers.
//   clk, rst_n           clock, async active-low reset (clears all entries)
//   we_i/waddr_i/wdata_i synchronous write port
//   raddr_a_i/rdata_a_o  asynchronous read port A
//   raddr_b_i/rdata_b_o  asynchronous read port B
module mc_regfile #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [2:0]        waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [2:0]        raddr_a_i,
  input  logic [2:0]        raddr_b_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o
);

  logic [DATA_W-1:0] regs_q [8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = regs_q[raddr_a_i];
  assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/mc_datapath.sv
// mc_datapath: multi-cycle datapath, one instruction in flight.
//   clk, rst_n            clock, async active-low reset
//   jump..reg_write_en    decoded controls (functions of opcode)
//   alu_op                ALU operation select
//   opcode                IR[15:12] back to the control unit
//   imem_*                instruction fetch req/ack port
//   dmem_*                data req/ack port, request held until ack
//   pc, retire            current PC, one-cycle pulse per retired instruction
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_FETCH  | request IR from imem at pc, wait for ack
// ST_DECODE | latch operands A/B from the register file
// ST_EXEC   | ALU op, latch ALUOut/zero, resolve jump/branch
// ST_MEM    | data access at ALUOut, wait for ack
// ST_WB     | register write-back, advance pc
module mc_datapath
  import mc_dp_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned PC_W     = 16,
  parameter int unsigned DADDR_W  = 16,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               jump,
  input  logic               beq,
  input  logic               bne,
  input  logic               mem_read_en,
  input  logic               mem_write_en,
  input  logic               alu_src,
  input  logic               reg_dst,
  input  logic               mem_to_reg,
  input  logic               reg_write_en,
  input  logic [2:0]         alu_op,
  output logic [3:0]         opcode,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [15:0]        imem_rdata,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic               dmem_ack,
  input  logic [DATA_W-1:0]  dmem_rdata,
  output logic [PC_W-1:0]    pc,
  output logic               retire
);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, alu_q, alu_d, mdr_q, mdr_d;
  logic              zero_q, zero_d;
  logic              retire_q, retire_d;
  logic              run_q;

  logic [DATA_W-1:0] rf_a, rf_b, rf_wdata, imm_sext, alu_b, alu_res;
  logic [2:0]        rf_waddr;
  logic              rf_we, alu_zero, br_taken;
  logic [PC_W-1:0]   pc_plus1, pc_branch, pc_jump;

  mc_regfile #(.DATA_W(DATA_W)) u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (rf_we),
    .waddr_i   (rf_waddr),
    .wdata_i   (rf_wdata),
    .raddr_a_i (ir_q[RS1_MSB:RS1_LSB]),
    .raddr_b_i (ir_q[RS2_MSB:RS2_LSB]),
    .rdata_a_o (rf_a),
    .rdata_b_o (rf_b)
  );

  assign rf_waddr = reg_dst ? ir_q[RD_MSB:RD_LSB] : ir_q[RS2_MSB:RS2_LSB];
  assign rf_wdata = mem_to_reg ? mdr_q : alu_q;

  assign imm_sext = {{(DATA_W-6){ir_q[IMM_MSB]}}, ir_q[IMM_MSB:IMM_LSB]};
  assign alu_b    = alu_src ? imm_sext : b_q;

  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_ADD: alu_res = a_q + alu_b;
      ALU_SUB: alu_res = a_q - alu_b;
      ALU_NOT: alu_res = ~a_q;
      ALU_SLL: alu_res = a_q << alu_b[3:0];
      ALU_SRL: alu_res = a_q >> alu_b[3:0];
      ALU_AND: alu_res = a_q & alu_b;
      ALU_OR:  alu_res = a_q | alu_b;
      ALU_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(alu_b))};
      default: alu_res = '0;
    endcase
  end

  // Branches resolve on the same-cycle ALU result so a taken branch retires
  // straight out of EXEC; zero_q keeps the architectural copy of the flag.
  assign alu_zero = (alu_res == '0);
  assign br_taken = (beq & alu_zero) | (bne & ~alu_zero);

  logic unused_zero;
  assign unused_zero = zero_q;

  assign pc_plus1  = pc_q + PC_W'(1);
  assign pc_branch = pc_plus1 + {{(PC_W-6){ir_q[IMM_MSB]}}, ir_q[IMM_MSB:IMM_LSB]};

  // Jump keeps the upper region of pc+1 and replaces the low 12 bits.
  if (PC_W > 12) begin : g_jump_hi
    assign pc_jump = {pc_plus1[PC_W-1:12], ir_q[JADDR_MSB:JADDR_LSB]};
  end else begin : g_jump_lo
    assign pc_jump = ir_q[JADDR_MSB:JADDR_LSB];
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    alu_d    = alu_q;
    mdr_d    = mdr_q;
    zero_d   = zero_q;
    retire_d = 1'b0;
    rf_we    = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        if (imem_req && imem_ack) begin
          ir_d    = imem_rdata;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        a_d     = rf_a;
        b_d     = rf_b;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        alu_d  = alu_res;
        zero_d = alu_zero;
        if (jump || br_taken) begin
          pc_d     = jump ? pc_jump : pc_branch;
          retire_d = 1'b1;
          state_d  = ST_FETCH;
        end else if (mem_read_en || mem_write_en) begin
          state_d = ST_MEM;
        end else if (reg_write_en) begin
          state_d = ST_WB;
        end else begin
          pc_d     = pc_plus1;
          retire_d = 1'b1;
          state_d  = ST_FETCH;
        end
      end
      ST_MEM: begin
        if (dmem_ack) begin
          // A simultaneous read+write request behaves as a plain store.
          if (mem_write_en) begin
            pc_d     = pc_plus1;
            retire_d = 1'b1;
            state_d  = ST_FETCH;
          end else begin
            mdr_d   = dmem_rdata;
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        rf_we    = reg_write_en;
        pc_d     = pc_plus1;
        retire_d = 1'b1;
        state_d  = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_FETCH;
      pc_q     <= PC_W'(RESET_PC);
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      alu_q    <= '0;
      mdr_q    <= '0;
      zero_q   <= 1'b0;
      retire_q <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      alu_q    <= alu_d;
      mdr_q    <= mdr_d;
      zero_q   <= zero_d;
      retire_q <= retire_d;
      run_q    <= 1'b1;
    end
  end

  // run_q holds off the first fetch request until the first edge after reset.
  assign imem_req   = (state_q == ST_FETCH) && run_q;
  assign imem_addr  = pc_q;
  assign dmem_req   = (state_q == ST_MEM);
  assign dmem_we    = dmem_req & mem_write_en;
  assign dmem_addr  = alu_q[DADDR_W-1:0];
  assign dmem_wdata = b_q;
  assign opcode     = ir_q[OPC_MSB:OPC_LSB];
  assign pc         = pc_q;
  assign retire     = retire_q;

endmodule

// File: tb/tb_mc_datapath.sv
// tb_mc_datapath: self-checking bench for mc_datapath (DATA_W=32, PC_W=16).
// The bench plays control unit (opcode -> controls), instruction memory and
// data memory, and tracks an instruction-level model of registers and pc.
//   op 0-7  R-type ALU, alu_op=op, rd=IR[5:3]
//   op 8    addi  R[rs2] = R[rs1] + imm
//   op 9    load  R[rs2] = M[R[rs1] + imm]
//   op 10   store M[R[rs1] + imm] = R[rs2]
//   op 11   beq, op 12 bne, op 13 jump
//   op 14   read+write together (acts as store)
//   op 15   nop
module tb_mc_datapath;
  localparam int DW = 32;
  localparam int PW = 16;
  localparam int AW = 16;

  logic          clk, rst_n;
  logic          jump, beq, bne, mem_read_en, mem_write_en, alu_src, reg_dst, mem_to_reg, reg_write_en;
  logic [2:0]    alu_op;
  logic [3:0]    opcode;
  logic          imem_req, imem_ack;
  logic [PW-1:0] imem_addr;
  logic [15:0]   imem_rdata;
  logic          dmem_req, dmem_we, dmem_ack;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata, dmem_rdata;
  logic [PW-1:0] pc;
  logic          retire;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] mreg [8];
  logic [PW-1:0] mpc;

  int            last_cyc, last_nd;
  logic [DW-1:0] last_wdata;
  logic [AW-1:0] last_addr;
  logic          last_we;

  mc_datapath #(.DATA_W(DW), .PC_W(PW), .DADDR_W(AW), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .jump(jump), .beq(beq), .bne(bne), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .alu_src(alu_src), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write_en(reg_write_en),
    .alu_op(alu_op), .opcode(opcode),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .pc(pc), .retire(retire)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    jump = 1'b0; beq = 1'b0; bne = 1'b0; mem_read_en = 1'b0; mem_write_en = 1'b0;
    alu_src = 1'b0; reg_dst = 1'b0; mem_to_reg = 1'b0; reg_write_en = 1'b0; alu_op = 3'b000;
    if (!opcode[3]) begin
      alu_op = opcode[2:0]; reg_dst = 1'b1; reg_write_en = 1'b1;
    end else begin
      case (opcode)
        4'd8:  begin alu_src = 1'b1; reg_write_en = 1'b1; end
        4'd9:  begin alu_src = 1'b1; mem_read_en = 1'b1; mem_to_reg = 1'b1; reg_write_en = 1'b1; end
        4'd10: begin alu_src = 1'b1; mem_write_en = 1'b1; end
        4'd11: begin alu_op = 3'b001; beq = 1'b1; end
        4'd12: begin alu_op = 3'b001; bne = 1'b1; end
        4'd13: jump = 1'b1;
        4'd14: begin alu_src = 1'b1; mem_read_en = 1'b1; mem_write_en = 1'b1;
                     mem_to_reg = 1'b1; reg_write_en = 1'b1; end
        default: ;
      endcase
    end
  end

  function automatic logic [DW-1:0] ref_alu(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return ~a;
      3'd3: return a << b[3:0];
      3'd4: return a >> b[3:0];
      3'd5: return a & b;
      3'd6: return a | b;
      default: return ($signed(a) < $signed(b)) ? DW'(1) : DW'(0);
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mreg[i] = '0;
    mpc = '0;
  endtask

  task automatic wait_fetch();
    int n = 0;
    while (!imem_req && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (imem_req !== 1'b1) begin
      failures++; $display("FAIL wait_fetch got imem_req=%b exp=1", imem_req);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    wait_fetch();
  endtask

  // Runs one instruction from its first FETCH cycle to the cycle after retire.
  task automatic exec_instr(input logic [15:0] ins, input int iw, input int dw, input logic [DW-1:0] rdv);
    logic [3:0]    op;
    logic [2:0]    rs1, rs2, rd;
    logic [DW-1:0] a, b, imm_d;
    logic [PW-1:0] imm_p, pc0, pc1, exp_pc;
    logic          is_mem, exp_we;
    logic [AW-1:0] exp_addr;
    int            exp_cyc, cyc, iwc, dwc, nd;
    bit            done;
    op = ins[15:12]; rs1 = ins[11:9]; rs2 = ins[8:6]; rd = ins[5:3];
    a = mreg[rs1]; b = mreg[rs2];
    imm_d = {{(DW-6){ins[5]}}, ins[5:0]};
    imm_p = {{(PW-6){ins[5]}}, ins[5:0]};
    pc0 = mpc; pc1 = mpc + 1'b1; exp_pc = pc1;
    is_mem = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_cyc = 3;
    if (!op[3]) begin
      mreg[rd] = ref_alu(op[2:0], a, b); exp_cyc = 4;
    end else begin
      case (op)
        4'd8:  begin mreg[rs2] = a + imm_d; exp_cyc = 4; end
        4'd9:  begin is_mem = 1'b1; exp_addr = AW'(a + imm_d); mreg[rs2] = rdv; exp_cyc = 5; end
        4'd10, 4'd14: begin is_mem = 1'b1; exp_we = 1'b1; exp_addr = AW'(a + imm_d); exp_cyc = 4; end
        4'd11: if (a == b) exp_pc = pc1 + imm_p;
        4'd12: if (a != b) exp_pc = pc1 + imm_p;
        4'd13: exp_pc = {pc1[15:12], ins[11:0]};
        default: ;
      endcase
    end
    exp_cyc += iw + (is_mem ? dw : 0);

    cyc = 0; iwc = 0; dwc = 0; nd = 0; done = 0;
    while (!done && cyc < exp_cyc + 10) begin
      imem_ack = 1'b0; dmem_ack = 1'b0;
      imem_rdata = 16'($urandom); dmem_rdata = DW'($urandom);
      if (imem_req) begin
        checks++;
        if (imem_addr !== pc0) begin
          failures++; $display("FAIL imem_addr got=%h exp=%h", imem_addr, pc0);
        end
        if (iwc == iw) begin imem_ack = 1'b1; imem_rdata = ins; end
        iwc++;
      end else begin
        imem_ack = 1'($urandom_range(0, 1));
      end
      if (dmem_req) begin
        checks++;
        if ({dmem_we, dmem_addr, dmem_wdata} !== {exp_we, exp_addr, b}) begin
          failures++;
          $display("FAIL dmem_port ins=%h got we=%b addr=%h wdata=%h exp we=%b addr=%h wdata=%h",
                   ins, dmem_we, dmem_addr, dmem_wdata, exp_we, exp_addr, b);
        end
        last_we = dmem_we; last_addr = dmem_addr; last_wdata = dmem_wdata;
        if (dwc == dw) begin dmem_ack = 1'b1; dmem_rdata = rdv; end
        dwc++; nd++;
      end else begin
        dmem_ack = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      cyc++;
      if (retire) done = 1;
    end
    imem_ack = 1'b0; dmem_ack = 1'b0;
    last_cyc = cyc; last_nd = nd;

    checks++;
    if (cyc != exp_cyc) begin
      failures++; $display("FAIL latency ins=%h got=%0d exp=%0d", ins, cyc, exp_cyc);
    end
    checks++;
    if (pc !== exp_pc) begin
      failures++; $display("FAIL pc_after ins=%h got=%h exp=%h", ins, pc, exp_pc);
    end
    checks++;
    if (nd != (is_mem ? dw + 1 : 0)) begin
      failures++; $display("FAIL dmem_req_cycles ins=%h got=%0d exp=%0d", ins, nd, is_mem ? dw + 1 : 0);
    end
    checks++;
    if (opcode !== op) begin
      failures++; $display("FAIL opcode got=%h exp=%h", opcode, op);
    end
    mpc = exp_pc;
  endtask

  task automatic dump_regs();
    for (int i = 0; i < 8; i++) exec_instr({4'd10, 3'd0, 3'(i), 6'd0}, 0, 0, '0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({pc, retire, dmem_req, imem_req, opcode} !== {16'h0000, 1'b0, 1'b0, 1'b0, 4'h0}) begin
      failures++;
      $display("FAIL reset_state got pc=%h retire=%b dmem_req=%b imem_req=%b opcode=%h exp 0000/0/0/0/0",
               pc, retire, dmem_req, imem_req, opcode);
    end
    rst_n = 1'b1; #1;
    checks++;
    if (imem_req !== 1'b0) begin
      failures++; $display("FAIL first_req_early got=%b exp=0", imem_req);
    end
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      failures++; $display("FAIL first_req got req=%b addr=%h exp 1/0000", imem_req, imem_addr);
    end
    model_reset();
  endtask

  task automatic test_add();
    do_reset();
    exec_instr({4'd8, 3'd0, 3'd0, 6'd3}, 0, 0, '0);
    checks++;
    if (pc !== 16'd1 || last_cyc != 4) begin
      failures++; $display("FAIL first_instr got pc=%h cyc=%0d exp 0001/4", pc, last_cyc);
    end
    exec_instr({4'd8, 3'd1, 3'd1, 6'd4}, 0, 0, '0);
    exec_instr({4'd0, 3'd0, 3'd1, 3'd2, 3'd0}, 0, 0, '0);
    exec_instr({4'd10, 3'd0, 3'd2, 6'd0}, 0, 0, '0);
    checks++;
    if (last_wdata !== 32'd7 || last_addr !== 16'd3) begin
      failures++; $display("FAIL add_r2 got wdata=%h addr=%h exp 7/3", last_wdata, last_addr);
    end
  endtask

  task automatic test_load_wait();
    exec_instr({4'd9, 3'd0, 3'd3, 6'd5}, 0, 3, 32'hDEADBEEF);
    checks++;
    if (last_cyc != 8 || last_nd != 4) begin
      failures++; $display("FAIL load_wait got cyc=%0d req=%0d exp 8/4", last_cyc, last_nd);
    end
    exec_instr({4'd10, 3'd0, 3'd3, 6'd0}, 1, 1, '0);
    checks++;
    if (last_wdata !== 32'hDEADBEEF) begin
      failures++; $display("FAIL load_value got=%h exp=deadbeef", last_wdata);
    end
  endtask

  task automatic test_branch();
    do_reset();
    for (int i = 0; i < 5; i++) exec_instr(16'hF000, 0, 0, '0);
    exec_instr({4'd11, 3'd0, 3'd0, 6'h3E}, 0, 0, '0);
    checks++;
    if (pc !== 16'd4) begin
      failures++; $display("FAIL beq_taken got=%h exp=0004", pc);
    end
    exec_instr(16'hF000, 0, 0, '0);
    exec_instr({4'd12, 3'd0, 3'd0, 6'h3E}, 0, 0, '0);
    checks++;
    if (pc !== 16'd6) begin
      failures++; $display("FAIL bne_not_taken got=%h exp=0006", pc);
    end
  endtask

  task automatic test_jump_wrap();
    exec_instr({4'd13, 12'hFFF}, 0, 0, '0);
    exec_instr(16'hF000, 0, 0, '0);
    exec_instr({4'd13, 12'hFFF}, 0, 0, '0);
    checks++;
    if (pc !== 16'h1FFF) begin
      failures++; $display("FAIL jump_setup got=%h exp=1fff", pc);
    end
    exec_instr({4'd13, 12'hABC}, 0, 0, '0);
    checks++;
    if (pc !== 16'h2ABC) begin
      failures++; $display("FAIL jump_region got=%h exp=2abc", pc);
    end
    for (int k = 0; k < 40 && mpc != 16'hFFFF; k++) begin
      if (mpc[11:0] == 12'hFFF) exec_instr(16'hF000, 0, 0, '0);
      else exec_instr({4'd13, 12'hFFF}, 0, 0, '0);
    end
    exec_instr({4'd12, 3'd0, 3'd0, 6'h05}, 0, 0, '0);
    checks++;
    if (pc !== 16'h0000) begin
      failures++; $display("FAIL pc_wrap got=%h exp=0000", pc);
    end
  endtask

  task automatic test_rw_both();
    exec_instr({4'd8, 3'd0, 3'd1, 6'd5}, 0, 0, '0);
    exec_instr({4'd14, 3'd0, 3'd1, 6'd2}, 0, 0, 32'h0BAD_F00D);
    checks++;
    if (last_we !== 1'b1 || last_cyc != 4) begin
      failures++; $display("FAIL rw_both got we=%b cyc=%0d exp 1/4", last_we, last_cyc);
    end
    dump_regs();
  endtask

  task automatic test_reset_mid_mem();
    int n;
    do_reset();
    exec_instr({4'd8, 3'd0, 3'd0, 6'd9}, 0, 0, '0);
    n = 0;
    while (!dmem_req && n < 10) begin
      imem_ack = imem_req; imem_rdata = {4'd9, 3'd0, 3'd2, 6'd4};
      @(negedge clk); n++;
    end
    imem_ack = 1'b0;
    checks++;
    if (dmem_req !== 1'b1) begin
      failures++; $display("FAIL reach_mem got dmem_req=%b exp=1", dmem_req);
    end
    @(negedge clk);
    rst_n = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678; #1;
    checks++;
    if (dmem_req !== 1'b0 || pc !== 16'h0000) begin
      failures++; $display("FAIL async_drop got dmem_req=%b pc=%h exp 0/0000", dmem_req, pc);
    end
    @(negedge clk);
    rst_n = 1'b1; imem_ack = 1'b1; imem_rdata = 16'hF000;
    model_reset();
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || pc !== 16'h0000 || dmem_req !== 1'b0) begin
      failures++; $display("FAIL late_ack got imem_req=%b pc=%h dmem_req=%b exp 1/0000/0", imem_req, pc, dmem_req);
    end
    imem_ack = 1'b0; dmem_ack = 1'b0;
    dump_regs();
    checks++;
    if (last_wdata !== 32'd0) begin
      failures++; $display("FAIL no_write_after_reset got=%h exp=0", last_wdata);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++)
      exec_instr(16'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), DW'($urandom));
    dump_regs();
  endtask

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = '0; dmem_rdata = '0;
    last_cyc = 0; last_nd = 0; last_wdata = '0; last_addr = '0; last_we = 1'b0;
    model_reset();
    test_reset();
    test_add();
    test_load_wait();
    test_branch();
    test_jump_wrap();
    test_rw_both();
    test_reset_mid_mem();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
